// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the cpu run monitor:
// state encoding, end-of-program opcode and dump record widths.
package cpu_dbg_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HOLD     = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_DUMP_RD  = 3'd4;
  localparam logic [2:0] ST_DUMP_OUT = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    HOLD     = ST_HOLD,
    RUN      = ST_RUN,
    DRAIN    = ST_DRAIN,
    DUMP_RD  = ST_DUMP_RD,
    DUMP_OUT = ST_DUMP_OUT,
    DONE     = ST_DONE
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  localparam int DUMP_IDX_W  = 5;
  localparam int DUMP_DATA_W = 32;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Register-dump stream: valid/ready with index and data.
// master = monitor (drives valid/idx/data), slave = sink (drives ready).
interface cpu_run_monitor_if
  import cpu_dbg_pkg::*;
#(
  parameter int XLEN      = DUMP_DATA_W,
  parameter int ADDR_SIZE = DUMP_IDX_W
);
  logic                 valid;
  logic                 ready;
  logic [ADDR_SIZE-1:0] idx;
  logic [XLEN-1:0]      data;

  modport master (
    output valid,
    output idx,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  idx,
    input  data,
    output ready
  );
endinterface

// File: rtl/cpu_run_monitor_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async high), clr, en, count.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller/observer: holds cpu in reset, runs it, detects end,
// drains, then streams the regfile out on the dump port.
// Ports: clk/rst, start/end_pc, fetch/EX/decode taps, cpu_rst/freeze,
// regfile debug read, dump stream, cycle/redirect/stall counters,
// done and timed_out status.
module cpu_run_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          REG_NUM      = 32,
  parameter int          ADDR_SIZE    = 5,
  parameter int          PC_BITS      = 5,
  parameter int          CYC_BITS     = 32,
  parameter int          RESET_CYCLES = 3,
  parameter int          DRAIN_CYCLES = 5,
  parameter int          TIMEOUT      = 2000,
  parameter logic [31:0] NOP_INST     = NOP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_BITS-1:0]   end_pc,
  input  logic [PC_BITS-1:0]   f_pc,
  input  logic [31:0]          f_inst,
  input  logic                 ex_taken,
  input  logic                 stall_d,
  output logic                 cpu_rst,
  output logic                 cpu_freeze,
  output logic [ADDR_SIZE-1:0] rf_raddr,
  input  logic [XLEN-1:0]      rf_rdata,
  cpu_run_monitor_if.master    dump,
  output logic [CYC_BITS-1:0]  cycles,
  output logic [CYC_BITS-1:0]  redirects,
  output logic [CYC_BITS-1:0]  stalls,
  output logic                 done,
  output logic                 timed_out
);

  localparam int PH_W = 16;

  state_t               state;
  logic [PH_W-1:0]      ph_cnt;
  logic [PC_BITS-1:0]   end_pc_q;
  logic                 in_run;
  logic                 start_ok;
  logic                 end_hit;
  logic                 to_hit;
  logic                 cnt_en;
  logic [CYC_BITS-1:0]  cycles_next;

  assign in_run   = (state == RUN);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  assign cycles_next = (cycles == '1) ? cycles : cycles + 1'b1;

  assign end_hit = in_run && (f_pc >= end_pc_q) && (f_inst == NOP_INST);

  // The timeout cycle itself is not counted, so cycles ends at TIMEOUT.
  assign to_hit = in_run && !end_hit && (TIMEOUT != 0)
                  && (cycles_next > CYC_BITS'(TIMEOUT));

  assign cnt_en = in_run && !to_hit;

  sat_counter #(.W(CYC_BITS)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (cnt_en),
    .count (cycles)
  );

  sat_counter #(.W(CYC_BITS)) u_redirects (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (cnt_en && ex_taken),
    .count (redirects)
  );

  sat_counter #(.W(CYC_BITS)) u_stalls (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (cnt_en && stall_d),
    .count (stalls)
  );

  // rf_raddr doubles as the dump index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      end_pc_q   <= '0;
      cpu_rst    <= 1'b1;
      cpu_freeze <= 1'b0;
      rf_raddr   <= '0;
      dump.valid <= 1'b0;
      dump.idx   <= '0;
      dump.data  <= '0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            end_pc_q   <= end_pc;
            ph_cnt     <= '0;
            cpu_rst    <= 1'b1;
            cpu_freeze <= 1'b0;
            rf_raddr   <= '0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (ph_cnt == PH_W'(RESET_CYCLES - 1)) begin
            cpu_rst <= 1'b0;
            state   <= RUN;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        RUN: begin
          if (end_hit) begin
            ph_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              cpu_freeze <= 1'b1;
              rf_raddr   <= '0;
              state      <= DUMP_RD;
            end else begin
              state <= DRAIN;
            end
          end else if (to_hit) begin
            timed_out  <= 1'b1;
            cpu_freeze <= 1'b1;
            rf_raddr   <= '0;
            state      <= DUMP_RD;
          end
        end
        DRAIN: begin
          if (ph_cnt == PH_W'(DRAIN_CYCLES - 1)) begin
            cpu_freeze <= 1'b1;
            rf_raddr   <= '0;
            state      <= DUMP_RD;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        DUMP_RD: begin
          dump.data  <= rf_rdata;
          dump.idx   <= rf_raddr;
          dump.valid <= 1'b1;
          state      <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (dump.ready) begin
            dump.valid <= 1'b0;
            if (rf_raddr == ADDR_SIZE'(REG_NUM - 1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rf_raddr <= rf_raddr + 1'b1;
              state    <= DUMP_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomised bench for cpu_run_monitor against a run-length model.
module tb_cpu_run_monitor;

  localparam int XLEN = 32;
  localparam int REG_NUM = 32;
  localparam int AW = 5;
  localparam int PCW = 5;
  localparam int CW = 32;
  localparam int RCYC = 3;
  localparam int DCYC = 5;
  localparam int TO = 2000;
  localparam int N = 2200;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [PCW-1:0] end_pc = 0;
  logic [PCW-1:0] f_pc = 0;
  logic [31:0] f_inst = 32'h13;
  logic ex_taken = 0;
  logic stall_d = 0;
  logic cpu_rst, cpu_freeze;
  logic [AW-1:0] rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic [CW-1:0] cycles, redirects, stalls;
  logic done, timed_out;

  cpu_run_monitor_if #(.XLEN(XLEN), .ADDR_SIZE(AW)) dif ();

  cpu_run_monitor #(
    .XLEN(XLEN), .REG_NUM(REG_NUM), .ADDR_SIZE(AW),
    .PC_BITS(PCW), .CYC_BITS(CW), .RESET_CYCLES(RCYC),
    .DRAIN_CYCLES(DCYC), .TIMEOUT(TO), .NOP_INST(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .end_pc(end_pc),
    .f_pc(f_pc), .f_inst(f_inst), .ex_taken(ex_taken),
    .stall_d(stall_d), .cpu_rst(cpu_rst),
    .cpu_freeze(cpu_freeze), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .dump(dif), .cycles(cycles),
    .redirects(redirects), .stalls(stalls), .done(done),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input int i);
    return (i == 0) ? 32'h0 : 32'hA5A5_0000 + i;
  endfunction

  logic [31:0] rf_mem [REG_NUM];
  assign rf_rdata = rf_mem[rf_raddr];

  logic [PCW-1:0] s_pc [N];
  logic [31:0] s_inst [N];
  bit s_ex [N];
  bit s_st [N];
  bit s_start [N];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic fill_bg(input bit rnd_ctl);
    for (int k = 0; k < N; k++) begin
      s_pc[k] = PCW'($urandom_range(0, 31));
      s_inst[k] = $urandom | 32'h1;
      s_ex[k] = rnd_ctl && ($urandom_range(0, 3) == 0);
      s_st[k] = rnd_ctl && ($urandom_range(0, 3) == 0);
      s_start[k] = 0;
    end
  endtask

  // Walk the program cycle by cycle: end on first NOP at/after
  // end PC, else stop once the count would exceed TO.
  task automatic model(input logic [PCW-1:0] epc,
                       output int kend, output bit is_to,
                       output int ec, output int er,
                       output int es);
    kend = N;
    is_to = 0;
    for (int k = 1; k < N; k++) begin
      if (s_pc[k] >= epc && s_inst[k] == 32'h0) begin
        kend = k;
        break;
      end
      if (TO != 0 && k > TO) begin
        kend = k;
        is_to = 1;
        break;
      end
    end
    ec = is_to ? kend - 1 : kend;
    er = 0;
    es = 0;
    for (int k = 1; k <= ec; k++) begin
      er += int'(s_ex[k]);
      es += int'(s_st[k]);
    end
  endtask

  task automatic run_one(input logic [PCW-1:0] epc,
                         input int abort_idx,
                         input int low_idx);
    int kend, ec, er, es, hold, k, exp_idx, cyc, low_cnt;
    bit is_to, prev_stall, saw_low, r;
    logic [AW-1:0] p_idx;
    logic [XLEN-1:0] p_data;
    model(epc, kend, is_to, ec, er, es);
    end_pc = epc;
    start = 1;
    @(negedge clk);
    start = 0;
    end_pc = PCW'($urandom);
    chk("clr_cycles", cycles, 0);
    chk("clr_redir", redirects, 0);
    chk("clr_stalls", stalls, 0);
    chk("clr_done", done, 0);
    chk("clr_to", timed_out, 0);
    chk("hold_freeze", cpu_freeze, 0);
    hold = 0;
    while (cpu_rst && hold < 10) begin
      hold++;
      @(negedge clk);
    end
    chk("hold_len", hold, RCYC);
    k = 1;
    while (!cpu_freeze && k < N) begin
      f_pc = s_pc[k];
      f_inst = s_inst[k];
      ex_taken = s_ex[k];
      stall_d = s_st[k];
      start = s_start[k];
      @(negedge clk);
      k++;
    end
    start = 0;
    f_inst = 32'h13;
    ex_taken = 0;
    stall_d = 0;
    chk("run_len", k - 1, is_to ? kend : kend + DCYC);
    chk("run_cycles", cycles, ec);
    exp_idx = 0;
    cyc = 0;
    prev_stall = 0;
    saw_low = 0;
    low_cnt = 0;
    p_idx = 0;
    p_data = 0;
    while (exp_idx < REG_NUM && cyc < 2000) begin
      if (prev_stall) begin
        chk("hold_valid", dif.valid, 1);
        chk("hold_idx", dif.idx, p_idx);
        chk("hold_data", dif.data, p_data);
      end
      if (abort_idx == exp_idx && dif.valid) begin
        rst = 1;
        #1;
        chk("abort_valid", dif.valid, 0);
        chk("abort_cpu_rst", cpu_rst, 1);
        chk("abort_freeze", cpu_freeze, 0);
        chk("abort_idx", dif.idx, 0);
        chk("abort_data", dif.data, 0);
        chk("abort_raddr", rf_raddr, 0);
        chk("abort_cycles", cycles, 0);
        chk("abort_done", done, 0);
        dif.ready = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        return;
      end
      if (dif.valid && int'(dif.idx) == low_idx && !saw_low) begin
        saw_low = 1;
        low_cnt = 7;
      end
      if (low_cnt > 0) begin
        r = 0;
        low_cnt--;
      end else begin
        r = bit'($urandom_range(0, 1));
      end
      dif.ready = r;
      if (dif.valid && r) begin
        chk("dump_idx", dif.idx, exp_idx);
        chk("dump_data", dif.data, rf_val(exp_idx));
        exp_idx++;
      end
      prev_stall = dif.valid && !r;
      p_idx = dif.idx;
      p_data = dif.data;
      @(negedge clk);
      cyc++;
    end
    dif.ready = 0;
    chk("dump_words", exp_idx, REG_NUM);
    chk("done", done, 1);
    chk("end_valid", dif.valid, 0);
    chk("end_freeze", cpu_freeze, 1);
    chk("cycles", cycles, ec);
    chk("redirects", redirects, er);
    chk("stalls", stalls, es);
    chk("timed_out", timed_out, is_to);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < REG_NUM; i++) rf_mem[i] = rf_val(i);
    dif.ready = 0;
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_freeze", cpu_freeze, 0);
    chk("rst_valid", dif.valid, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", rf_raddr, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("idle_cpu_rst", cpu_rst, 1);

    // exact redirect/stall pulses, including some during DRAIN
    fill_bg(0);
    for (int k = 1; k < 20; k++) s_pc[k] = PCW'(k % 22);
    s_pc[20] = 22;
    s_inst[20] = 0;
    s_ex[5] = 1; s_ex[9] = 1; s_ex[12] = 1;
    s_st[3] = 1; s_st[4] = 1; s_st[10] = 1; s_st[11] = 1;
    s_ex[21] = 1; s_ex[23] = 1; s_st[22] = 1; s_st[24] = 1;
    run_one(22, -1, -1);

    // straight-line program ending at PC 22, cycle 40
    fill_bg(1);
    for (int k = 1; k < 40; k++) s_pc[k] = PCW'((k - 1) % 22);
    s_pc[40] = 22;
    s_inst[40] = 0;
    run_one(22, -1, 5);

    // early NOP below end PC is not an end
    fill_bg(1);
    s_pc[15] = 10;
    s_inst[15] = 0;
    s_pc[30] = 23;
    s_inst[30] = 0;
    run_one(22, -1, -1);

    // pure timeout
    fill_bg(1);
    run_one(22, -1, -1);

    // end detect on the timeout cycle
    fill_bg(1);
    s_pc[TO + 1] = 25;
    s_inst[TO + 1] = 0;
    run_one(22, -1, -1);

    // random program, reset mid-dump
    fill_bg(1);
    for (int k = 1; k < N; k++)
      if ($urandom_range(0, 7) == 0) s_inst[k] = 0;
    run_one(PCW'($urandom_range(0, 20)), 12, -1);

    // fresh run from IDLE with ignored start pulses
    fill_bg(1);
    for (int k = 1; k < N; k++)
      if ($urandom_range(0, 7) == 0) s_inst[k] = 0;
    s_start[2] = 1;
    s_start[3] = 1;
    run_one(PCW'($urandom_range(0, 20)), -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run controller and observer for the pipelined cpu, parametrised in XLEN/REG_NUM/PC_BITS.
- Holds the core in reset for a programmable number of cycles, then releases it.
- Counts cycles, EX redirects and decode stalls.
- Detects end-of-program: first NOP fetched at or after a runtime end PC.
- Drains the pipeline, then streams the register file out over a valid/ready port.
- Sits beside cpu in the top-level harness; replaces simulation-only run/dump loops, so it works on FPGA and in regression.

Parameters:
XLEN, 32, register/data width
REG_NUM, 32, registers dumped (indices 0..REG_NUM-1)
ADDR_SIZE, 5, register index width
PC_BITS, 5, fetch PC width
CYC_BITS, 32, width of all counters
RESET_CYCLES, 3, cycles cpu_rst held after start (>=1)
DRAIN_CYCLES, 5, cycles after end detect before dump (0 allowed)
TIMEOUT, 2000, RUN-cycle limit; 0 disables
NOP_INST, 32'h00000000, end-of-program instruction encoding

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin run (accepted in IDLE or DONE only)
end_pc  in  PC_BITS  end PC, sampled on start acceptance
f_pc  in  PC_BITS  fetch-stage PC
f_inst  in  32  fetch-stage instruction
ex_taken  in  1  EX redirect this cycle
stall_d  in  1  decode stall this cycle
cpu_rst  out  1  reset to cpu
cpu_freeze  out  1  clock-enable-low to cpu
rf_raddr  out  ADDR_SIZE  regfile debug read address (combinational read)
rf_rdata  in  XLEN  regfile debug read data
dump_valid  out  1  dump word valid
dump_ready  in  1  sink ready
dump_idx  out  ADDR_SIZE  register index of dump word
dump_data  out  XLEN  register value
cycles  out  CYC_BITS  RUN cycles
redirects  out  CYC_BITS  ex_taken count in RUN
stalls  out  CYC_BITS  stall_d count in RUN
done  out  1  dump complete
timed_out  out  1  run ended by TIMEOUT

Behaviour:
- FSM states: IDLE, HOLD, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE.
- Reset (async, any state): state=IDLE, all counters 0, cpu_rst=1, cpu_freeze=0, dump_valid=0, dump_idx=0, dump_data=0, rf_raddr=0, done=0, timed_out=0.
- IDLE: cpu_rst=1. On start:
  - latch end_pc;
  - clear cycles, redirects, stalls, done, timed_out;
  - go to HOLD.
- HOLD: cpu_rst=1 for exactly RESET_CYCLES clocks, then RUN. cpu_rst is a registered output and falls on the edge entering RUN.
- RUN: each cycle, cycles_next=cycles+1; redirects += ex_taken; stalls += stall_d. All counters saturate at all-ones.
  - End detect: f_pc >= latched end_pc (unsigned) AND f_inst==NOP_INST → DRAIN (DUMP_RD if DRAIN_CYCLES=0). The detect cycle is counted.
  - Else, if TIMEOUT!=0 and cycles_next > TIMEOUT: timed_out=1 → DUMP_RD. No drain.
  - End detect and timeout in the same cycle: end detect wins; timed_out stays 0.
- DRAIN: core keeps running and counters are frozen. After exactly DRAIN_CYCLES clocks → DUMP_RD with idx=0.
- DUMP_RD, DUMP_OUT, DONE all drive cpu_freeze=1 (core state held).
- DUMP_RD (1 cycle): rf_raddr=idx; capture rf_rdata into dump_data and idx into dump_idx; → DUMP_OUT.
- DUMP_OUT: dump_valid=1. dump_data and dump_idx stay stable while dump_valid && !dump_ready.
  - On handshake, if idx==REG_NUM-1 → DONE; else idx+1 → DUMP_RD.
  - Minimum 2 cycles per word.
  - Register 0 is dumped as read (expected 0).
- DONE: done=1, counters and timed_out held. start → HOLD with the same clearing as IDLE (cpu_rst=1 again, cpu_freeze=0).
- start asserted in any other state is ignored.
- rst mid-dump aborts with no partial-word guarantee; dump_valid drops asynchronously.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - state encoding localparams (3 bits);
  - NOP_INST default;
  - the dump record field widths.
- One sub-module: sat_counter (CYC_BITS, enable, clear, saturating), instantiated three times.
- FSM, dump sequencer and end detector stay in cpu_run_monitor.

Test Plan:
1. Defaults, end_pc=22; program feeds f_inst!=0 at PCs 0..21, then 0 at PC 22 on RUN cycle 40 → DRAIN 5 cycles, 32 dump words idx 0..31, cycles=40, timed_out=0, done=1.
2. TIMEOUT=2000, f_inst never 0 → leaves RUN when cycles=2000, timed_out=1, no DRAIN cycles, full dump follows.
3. NOP at f_pc=10 with end_pc=22, then NOP at f_pc=23 → only the PC 23 fetch ends the run. Variant with end detect on the same cycle as timeout → timed_out=0.
4. dump_ready toggled randomly, held low 7 cycles at idx=5 → dump_data/dump_idx stable, no word lost or duplicated; rf_rdata=0xA5A5_0000+idx yields matching data.
5. ex_taken pulsed 3× and stall_d 4× in RUN, plus 2× in DRAIN → redirects=3, stalls=4; cpu_rst high exactly 3 cycles after start.
6. rst asserted mid-DUMP_OUT (idx=12) → immediate IDLE, outputs at reset values. start from DONE → counters cleared, new run completes.
